// File: rtl/watchdog_pkg.sv
// Shared definitions for the cycle watchdog: state encoding and its width.
package watchdog_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_LOAD    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXPIRED = 2'd3
    } wd_state_t;

endpackage

// File: rtl/cycle_watchdog_if.sv
// Control/status bundle of the cycle watchdog; master drives config and heartbeat.
interface cycle_watchdog_if #(
    parameter int WIDTH = 32
);
    import watchdog_pkg::*;

    logic [WIDTH-1:0] cfg_limit;
    logic             enable;
    logic             kick;
    logic             expire_ack;
    logic [WIDTH-1:0] count;
    logic             warn;
    logic             expire_req;
    logic             expired;
    wd_state_t        state;

    modport master (
        output cfg_limit, enable, kick, expire_ack,
        input  count, warn, expire_req, expired, state
    );

    modport slave (
        input  cfg_limit, enable, kick, expire_ack,
        output count, warn, expire_req, expired, state
    );

endinterface

// File: rtl/cycle_watchdog.sv
// Cycle watchdog: latches a limit once after reset, then counts enabled cycles
// between kicks and raises a sticky timeout with an acknowledged request.
module cycle_watchdog
    import watchdog_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int WARN_SHIFT = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    cycle_watchdog_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    wd_state_t        state_r;
    wd_state_t        state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_s;
    logic             req_r;
    logic             req_s;
    logic             expired_r;
    logic             expired_s;

    // State, counter, latched limit and timeout flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_LOAD;
            count_r   <= '0;
            limit_r   <= '0;
            req_r     <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            limit_r   <= limit_s;
            req_r     <= req_s;
            expired_r <= expired_s;
        end
    end

    // Next-state decode; disable beats kick, kick beats expiry
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        limit_s   = limit_r;
        req_s     = req_r;
        expired_s = expired_r;
        case (state_r)
            ST_LOAD: begin
                limit_s = bus.cfg_limit;
                count_s = '0;
                state_s = ST_IDLE;
            end
            ST_IDLE: begin
                count_s = '0;
                if (bus.enable && (limit_r != '0)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.enable) begin
                    state_s = ST_IDLE;
                    count_s = '0;
                end else if (bus.kick) begin
                    count_s = '0;
                end else if (count_r == (limit_r - ONE)) begin
                    // Saturate at the limit itself so an all-ones limit never wraps
                    count_s   = limit_r;
                    state_s   = ST_EXPIRED;
                    req_s     = 1'b1;
                    expired_s = 1'b1;
                end else begin
                    count_s = count_r + ONE;
                end
            end
            ST_EXPIRED: begin
                count_s   = limit_r;
                expired_s = 1'b1;
                if (req_r && bus.expire_ack) begin
                    req_s = 1'b0;
                end else begin
                    req_s = req_r;
                end
            end
            default: begin
                state_s   = ST_LOAD;
                count_s   = '0;
                limit_s   = '0;
                req_s     = 1'b0;
                expired_s = 1'b0;
            end
        endcase
    end

    assign bus.count      = count_r;
    assign bus.state      = state_r;
    assign bus.expire_req = req_r;
    assign bus.expired    = expired_r;
    assign bus.warn       = (state_r == ST_RUN) && (count_r >= (limit_r >> WARN_SHIFT));

endmodule

// File: doc/cycle_watchdog.md
CYCLE_WATCHDOG -- requirements
Module: cycle_watchdog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of the cycle limit and of the counter.
REQ-002 The block SHALL have parameter WARN_SHIFT, default 1: sets the warning threshold to limit_q >> WARN_SHIFT.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_limit, input, WIDTH bits: cycle limit, driven by the plusarg reader output and static after reset; 0 means watchdog disabled.
REQ-006 The block SHALL have port enable, input, 1 bit: arms counting while high.
REQ-007 The block SHALL have port kick, input, 1 bit: heartbeat that restarts the count.
REQ-008 The block SHALL have port expire_ack, input, 1 bit: acknowledge for expire_req.
REQ-009 The block SHALL have port count, output, WIDTH bits: current cycle count.
REQ-010 The block SHALL have port warn, output, 1 bit: high while state is RUN and count >= (limit_q >> WARN_SHIFT).
REQ-011 The block SHALL have port expire_req, output, 1 bit: timeout request, held until acknowledged.
REQ-012 The block SHALL have port expired, output, 1 bit: sticky timeout flag.
REQ-013 The block SHALL have port state, output, 2 bits: encoding LOAD=0, IDLE=1, RUN=2, EXPIRED=3.

Function
REQ-014 LOAD SHALL last exactly one cycle after reset release: latch limit_q <= cfg_limit, then go to IDLE; cfg_limit SHALL be ignored thereafter.
REQ-015 In IDLE, count SHALL be 0; if enable=1 and limit_q!=0, next state SHALL be RUN with count 0; if limit_q=0, the block SHALL stay in IDLE permanently.
REQ-016 In RUN with enable=0, the next state SHALL be IDLE with count 0; disable SHALL take priority over kick and over expiry.
REQ-017 In RUN with enable=1 and kick=1, count SHALL be set to 0 next cycle; kick SHALL take priority over expiry in the same cycle.
REQ-018 In RUN with enable=1 and kick=0, count SHALL increment by 1; when count = limit_q-1, the next cycle SHALL have count=limit_q, state=EXPIRED, expire_req=1, expired=1 (expiry after exactly limit_q cycles without kick).
REQ-019 count SHALL never wrap; limit_q = all-ones SHALL expire at the all-ones count, with no overflow.
REQ-020 In EXPIRED, count SHALL hold limit_q, enable and kick SHALL be ignored, and the block SHALL leave EXPIRED only by reset.
REQ-021 expire_req SHALL fall on the cycle after expire_ack is sampled high while expire_req=1; expire_ack while expire_req=0 SHALL be ignored; expired SHALL remain 1.
REQ-022 warn SHALL be combinational from state, count and limit_q; all other outputs SHALL be registered.
REQ-023 kick in IDLE or LOAD SHALL have no effect.

Reset
REQ-024 While reset_n=0, the block SHALL force state=LOAD, count=0, limit_q=0, expire_req=0, expired=0 and warn=0, regardless of clock.
REQ-025 Reset asserted in any state, including mid-RUN or EXPIRED with a pending request, SHALL abandon the operation with no residual request.

Structure
REQ-026 The state encoding enum and its width constant SHALL live in shared package watchdog_pkg.
REQ-027 The block SHALL be a single module; the plusarg reader is instantiated by the parent, not inside.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, cfg_limit=5, enable=1 held, no kick -> RUN entered at cycle 2; expire_req/expired rise exactly 5 cycles after RUN entry; count=5.
REQ-029 The bench SHALL cover: cfg_limit=5, kick on the cycle count=4 -> count=0 next, no expiry; expiry 5 cycles after the last kick.
REQ-030 The bench SHALL cover: cfg_limit=0, enable=1 for 100 cycles -> state stays IDLE, expired=0.
REQ-031 The bench SHALL cover: cfg_limit=8, WARN_SHIFT=1 -> warn high from count=4 through 7; enable dropped at count=6 -> IDLE, count=0, warn=0.
REQ-032 The bench SHALL cover: expired, expire_ack pulsed -> expire_req=0 next cycle, expired=1; cfg_limit changed to 3 -> no effect.
REQ-033 The bench SHALL cover: WIDTH=4, cfg_limit=15 -> expiry at count=15, no wrap; reset_n pulsed mid-EXPIRED -> all outputs 0, LOAD, then IDLE.
